// File: rtl/axi_rd_scheduler.sv
// Read-path scheduler: grants one of two masters the shared AR/R channels for a whole burst.
// Build option AXI_RD_SCHED_RR_EN selects round-robin arbitration; default is fixed priority (M1 wins).
module axi_rd_scheduler #(
  parameter int unsigned LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ARVALID_M0,
  input  logic                ARVALID_M1,
  input  logic [LEN_BITS-1:0] ARLEN_M0,
  input  logic [LEN_BITS-1:0] ARLEN_M1,
  output logic                ARREADY_M0,
  output logic                ARREADY_M1,
  output logic                ARVALID_S,
  input  logic                ARREADY_S,
  input  logic                RVALID_S,
  input  logic                RLAST_S,
  output logic                RREADY_S,
  input  logic                RREADY_M0,
  input  logic                RREADY_M1,
  output logic                RVALID_M0,
  output logic                RVALID_M1,
  output logic                SEL_M1,
  output logic                BUSY,
  output logic                LEN_ERR
);

  localparam logic [LEN_BITS-1:0] CNT_MAX = {LEN_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [LEN_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic                len_err_q, len_err_d;
  logic                pick_m1;
  logic                owner_arvalid;
  logic                owner_rready;
  logic                ar_hs;
  logic                r_beat;

`ifdef AXI_RD_SCHED_RR_EN
  logic last_m1_q, last_m1_d;

  // On a tie the master that did not own the previous transaction wins.
  assign pick_m1 = ARVALID_M1 && (!ARVALID_M0 || !last_m1_q);
`else
  assign pick_m1 = ARVALID_M1;
`endif

  // Channel gating depends only on registered state and select, never on the arbitration result.
  assign owner_arvalid = sel_q ? ARVALID_M1 : ARVALID_M0;
  assign owner_rready  = sel_q ? RREADY_M1  : RREADY_M0;

  assign ARVALID_S  = (state_q == ADDR) && owner_arvalid;
  assign ARREADY_M0 = (state_q == ADDR) && !sel_q && ARREADY_S;
  assign ARREADY_M1 = (state_q == ADDR) &&  sel_q && ARREADY_S;
  assign RREADY_S   = (state_q == DATA) && owner_rready;
  assign RVALID_M0  = (state_q == DATA) && !sel_q && RVALID_S;
  assign RVALID_M1  = (state_q == DATA) &&  sel_q && RVALID_S;
  assign SEL_M1     = sel_q;
  assign BUSY       = (state_q != IDLE);
  assign LEN_ERR    = len_err_q;

  assign ar_hs  = ARVALID_S && ARREADY_S;
  assign r_beat = RVALID_S && RREADY_S;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
`ifdef AXI_RD_SCHED_RR_EN
      last_m1_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
`ifdef AXI_RD_SCHED_RR_EN
      last_m1_q  <= last_m1_d;
`endif
    end
  end

  // Next-state: grant in IDLE, AR handshake in ADDR, beat counting and length check in DATA.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = 1'b0;
`ifdef AXI_RD_SCHED_RR_EN
    last_m1_d  = last_m1_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ARVALID_M0 || ARVALID_M1) begin
          sel_d   = pick_m1;
          len_d   = pick_m1 ? ARLEN_M1 : ARLEN_M0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (r_beat) begin
          if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + LEN_BITS'(1);
          end
          if (RLAST_S) begin
            state_d   = IDLE;
            len_err_d = (beat_cnt_q != len_q);
`ifdef AXI_RD_SCHED_RR_EN
            last_m1_d = sel_q;
`endif
          end else if (beat_cnt_q == len_q) begin
            // Burst overran its length; keep the channel until the slave ends it.
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Directed bench for axi_rd_scheduler: transaction-level model checked every cycle plus literal pins.
// Build with +define+AXI_RD_SCHED_RR_EN for the round-robin variant.
module tb_axi_rd_scheduler;

  localparam int unsigned LEN_BITS = 4;
  localparam int          CNT_MAX  = (1 << LEN_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
  logic [LEN_BITS-1:0] ARLEN_M0 = '0, ARLEN_M1 = '0;
  logic                ARREADY_M0, ARREADY_M1, ARVALID_S;
  logic                ARREADY_S = 1'b1;
  logic                RVALID_S = 1'b0, RLAST_S = 1'b0;
  logic                RREADY_S;
  logic                RREADY_M0 = 1'b1, RREADY_M1 = 1'b1;
  logic                RVALID_M0, RVALID_M1, SEL_M1, BUSY, LEN_ERR;

  axi_rd_scheduler #(.LEN_BITS(LEN_BITS)) dut (
    .clk(clk), .rst(rst),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RVALID_S(RVALID_S), .RLAST_S(RLAST_S), .RREADY_S(RREADY_S),
    .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
    .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
    .SEL_M1(SEL_M1), .BUSY(BUSY), .LEN_ERR(LEN_ERR)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- transaction-level model ----------------
  // phase: 0 no grant, 1 address owed by owner, 2 data flowing to owner
  int   m_phase = 0, m_own = 0, m_len = 0, m_beats = 0, m_last = 1;
  logic m_err = 1'b0;

  function automatic int model_pick();
    if (ARVALID_M0 && ARVALID_M1) begin
`ifdef AXI_RD_SCHED_RR_EN
      return (m_last == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return ARVALID_M1 ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_own = 0; m_len = 0; m_beats = 0; m_last = 1; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_phase == 0) begin
        if (ARVALID_M0 || ARVALID_M1) begin
          m_own   = model_pick();
          m_len   = (m_own == 1) ? int'(ARLEN_M1) : int'(ARLEN_M0);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (((m_own == 1) ? ARVALID_M1 : ARVALID_M0) && ARREADY_S) begin
          m_beats = 0;
          m_phase = 2;
        end
      end else if (RVALID_S && ((m_own == 1) ? RREADY_M1 : RREADY_M0)) begin
        if (RLAST_S) begin
          m_err   = (m_beats != m_len);
          m_phase = 0;
          m_last  = m_own;
        end else if (m_beats == m_len) begin
          m_err = 1'b1;
        end
        if (m_beats < CNT_MAX) m_beats++;
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic adr, dat, o1;
    adr = (m_phase == 1);
    dat = (m_phase == 2);
    o1  = (m_own == 1);
    chk1("ARVALID_S",  ARVALID_S,  adr && (o1 ? ARVALID_M1 : ARVALID_M0));
    chk1("ARREADY_M0", ARREADY_M0, adr && !o1 && ARREADY_S);
    chk1("ARREADY_M1", ARREADY_M1, adr && o1 && ARREADY_S);
    chk1("RVALID_M0",  RVALID_M0,  dat && !o1 && RVALID_S);
    chk1("RVALID_M1",  RVALID_M1,  dat && o1 && RVALID_S);
    chk1("RREADY_S",   RREADY_S,   dat && (o1 ? RREADY_M1 : RREADY_M0));
    chk1("SEL_M1",     SEL_M1,     o1);
    chk1("BUSY",       BUSY,       m_phase != 0);
    chk1("LEN_ERR",    LEN_ERR,    m_err);
  endtask

  // ---------------- stimulus agents ----------------
  logic pend0 = 1'b0, pend1 = 1'b0, mask0 = 1'b0;
  int   len0 = 0, len1 = 0;
  logic s_active = 1'b0, rready = 1'b1;
  int   s_idx = 0, s_last_idx = 0, stall_idx = -1, stall_left = 0;
  int   plan_q[$];
  int   grant_q[$];
  int   cyc = 0, cur_beats = 0, last_beats = -1, err_pulses = 0, stall_seen = 0;

  task automatic drive();
    ARVALID_M0 = pend0 && !mask0;
    ARVALID_M1 = pend1;
    ARLEN_M0   = LEN_BITS'(len0);
    ARLEN_M1   = LEN_BITS'(len1);
    RVALID_S   = s_active;
    RLAST_S    = s_active && (s_idx == s_last_idx);
    RREADY_M0  = rready;
    RREADY_M1  = rready;
  endtask

  // One clock: sample handshakes mid-cycle, then update agents just after the edge.
  task automatic step();
    logic h_m0, h_m1, h_ar, h_r, h_last;
    @(negedge clk);
    h_m0   = ARVALID_M0 && ARREADY_M0;
    h_m1   = ARVALID_M1 && ARREADY_M1;
    h_ar   = ARVALID_S && ARREADY_S;
    h_r    = RVALID_S && RREADY_S;
    h_last = RLAST_S;
    if (LEN_ERR) err_pulses++;
    if (RVALID_S && !RREADY_S) stall_seen++;
    @(posedge clk);
    #1;
    cyc++;
    if (h_m0) pend0 = 1'b0;
    if (h_m1) pend1 = 1'b0;
    if (h_r) begin
      cur_beats++;
      if (h_last) begin
        last_beats = cur_beats;
        cur_beats  = 0;
        s_active   = 1'b0;
      end else begin
        s_idx++;
      end
    end
    if (h_ar) begin
      grant_q.push_back(h_m1 ? 1 : 0);
      s_active   = 1'b1;
      s_idx      = 0;
      s_last_idx = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
    end
    rready = 1'b1;
    if (s_active && s_idx == stall_idx && stall_left > 0) begin
      rready = 1'b0;
      stall_left--;
    end
    drive();
  endtask

  task automatic issue(input int m, input int len);
    if (m == 0) begin pend0 = 1'b1; len0 = len; end
    else        begin pend1 = 1'b1; len1 = len; end
    drive();
  endtask

  task automatic clear_agents();
    pend0 = 1'b0; pend1 = 1'b0; mask0 = 1'b0;
    s_active = 1'b0; rready = 1'b1; stall_idx = -1; stall_left = 0;
    cur_beats = 0; ARREADY_S = 1'b1;
    plan_q.delete();
    grant_q.delete();
    drive();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_agents();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_until_quiet(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!pend0 && !pend1 && !s_active && !BUSY) return;
    end
    miscompares++;
    $display("FAIL %s: timeout after %0d cycles, expected return to idle", name, budget);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c0, e0, st0;
    logic found;

    fork
      forever begin
        @(negedge clk);
        compare_all();
      end
    join_none

    #1;
    reset_dut();
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_sel", SEL_M1, 1'b0);
    chk1("rst_arvalid_s", ARVALID_S, 1'b0);

    // Single M0 single-beat read: AR one cycle after request, idle three edges after request.
    plan_q.push_back(0);
    issue(0, 0);
    c0 = cyc;
    e0 = err_pulses;
    step();
    chk1("t1_arvalid_s_latency", ARVALID_S, 1'b1);
    chk1("t1_sel", SEL_M1, 1'b0);
    run_until_quiet("t1_done", 20);
    chki("t1_cycles", cyc - c0, 3);
    step();
    chki("t1_beats", last_beats, 1);
    chki("t1_len_err", err_pulses - e0, 0);

    // Two ties in a row, 4 beats each.
    reset_dut();
    for (int i = 0; i < 4; i++) plan_q.push_back(3);
    issue(0, 3);
    issue(1, 3);
    run_until_quiet("t2_first_tie", 60);
    issue(0, 3);
    issue(1, 3);
    run_until_quiet("t2_second_tie", 60);
    step();
    chki("t2_grants", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
`ifdef AXI_RD_SCHED_RR_EN
      chki("t2_grant0", grant_q[0], 0);
      chki("t2_grant1", grant_q[1], 1);
      chki("t2_grant2", grant_q[2], 0);
      chki("t2_grant3", grant_q[3], 1);
`else
      chki("t2_grant0", grant_q[0], 1);
      chki("t2_grant1", grant_q[1], 0);
      chki("t2_grant2", grant_q[2], 1);
      chki("t2_grant3", grant_q[3], 0);
`endif
    end
    chki("t2_beats", last_beats, 4);

    // M1 burst of 4 with two stall cycles on the second beat.
    reset_dut();
    plan_q.push_back(3);
    stall_idx  = 1;
    stall_left = 2;
    st0 = stall_seen;
    e0  = err_pulses;
    issue(1, 3);
    run_until_quiet("t3_done", 30);
    step();
    chki("t3_beats", last_beats, 4);
    chki("t3_stall_cycles", stall_seen - st0, 2);
    chki("t3_len_err", err_pulses - e0, 0);

    // ARLEN=3 but RLAST on the second beat: early termination.
    reset_dut();
    plan_q.push_back(1);
    e0 = err_pulses;
    issue(0, 3);
    run_until_quiet("t4_done", 30);
    step();
    chki("t4_beats", last_beats, 2);
    chki("t4_len_err", err_pulses - e0, 1);

    // ARLEN=1 with RLAST only on the third beat: overrun pulse, then mismatched last.
    reset_dut();
    plan_q.push_back(2);
    e0 = err_pulses;
    issue(1, 1);
    run_until_quiet("t5_done", 30);
    step();
    chki("t5_beats", last_beats, 3);
    chki("t5_len_err", err_pulses - e0, 2);

    // Owner drops ARVALID in ADDR while M1 also requests; grant is kept.
    reset_dut();
    ARREADY_S = 1'b0;
    plan_q.push_back(2);
    plan_q.push_back(1);
    issue(0, 2);
    step();
    chk1("t6_arvalid_s_up", ARVALID_S, 1'b1);
    issue(1, 1);
    mask0 = 1'b1;
    drive();
    step();
    chk1("t6_arvalid_s_dropped", ARVALID_S, 1'b0);
    chk1("t6_busy_held", BUSY, 1'b1);
    chk1("t6_sel_held", SEL_M1, 1'b0);
    mask0 = 1'b0;
    drive();
    step();
    chk1("t6_arvalid_s_back", ARVALID_S, 1'b1);
    ARREADY_S = 1'b1;
    run_until_quiet("t6_done", 40);
    chki("t6_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      chki("t6_grant0", grant_q[0], 0);
      chki("t6_grant1", grant_q[1], 1);
    end

    // Reset asserted mid-burst, then a fresh M1 request.
    reset_dut();
    plan_q.push_back(3);
    issue(1, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_active && s_idx == 1) found = 1'b1;
    end
    chk1("t7_reached_beat", found, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("t7_rst_busy", BUSY, 1'b0);
    chk1("t7_rst_rready_s", RREADY_S, 1'b0);
    chk1("t7_rst_rvalid_m1", RVALID_M1, 1'b0);
    chk1("t7_rst_sel", SEL_M1, 1'b0);
    chk1("t7_rst_arvalid_s", ARVALID_S, 1'b0);
    clear_agents();
    step();
    step();
    rst = 1'b0;
    plan_q.push_back(0);
    issue(1, 0);
    step();
    chk1("t7_arvalid_s_after_rst", ARVALID_S, 1'b1);
    chk1("t7_sel_after_rst", SEL_M1, 1'b1);
    run_until_quiet("t7_done", 20);
    step();
    chki("t7_beats", last_beats, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
